// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: AXI read-channel payload types, response codes and the
// arbiter FSM encoding. TERM/DRAIN exist only with AXI_RD_ARB_TIMEOUT_EN.
package axi_rd_arbiter_pkg;

   localparam int unsigned ID_BITS    = 4;
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned LEN_BITS   = 8;
   localparam int unsigned SIZE_BITS  = 3;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned RESP_BITS  = 3;

   localparam logic [RESP_BITS-1:0] RESP_OKAY   = 3'b000;
   localparam logic [RESP_BITS-1:0] RESP_SLVERR = 3'b010;
   localparam logic [1:0]           BURST_INCR  = 2'b01;

   typedef struct packed {
      logic [ID_BITS-1:0]    id;
      logic [ADDR_WIDTH-1:0] addr;
      logic [LEN_BITS-1:0]   len;
      logic [1:0]            burst;
      logic [SIZE_BITS-1:0]  size;
   } ar_t;

   typedef struct packed {
      logic [ID_BITS-1:0]    id;
      logic [DATA_WIDTH-1:0] data;
      logic [RESP_BITS-1:0]  resp;
      logic                  last;
   } r_t;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
`ifdef AXI_RD_ARB_TIMEOUT_EN
      StData,
      StTerm,
      StDrain
`else
      StData
`endif
   } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AR/R signals between NUM_M masters, the read arbiter and one
// slave. Modport "slave" is the arbiter's view (it terminates the masters' bus);
// modport "master" is the surrounding fabric: the masters plus the downstream slave.
interface axi_rd_arbiter_if import axi_rd_arbiter_pkg::*; #(
   parameter int unsigned NUM_M = 2
);

   ar_t  [NUM_M-1:0] m_ar;
   logic [NUM_M-1:0] m_arvalid;
   logic [NUM_M-1:0] m_arready;
   r_t   [NUM_M-1:0] m_r;
   logic [NUM_M-1:0] m_rvalid;
   logic [NUM_M-1:0] m_rready;

   ar_t  s_ar;
   logic s_arvalid;
   logic s_arready;
   r_t   s_r;
   logic s_rvalid;
   logic s_rready;

   modport slave (
      input  m_ar, m_arvalid, m_rready, s_arready, s_r, s_rvalid,
      output m_arready, m_r, m_rvalid, s_ar, s_arvalid, s_rready
   );

   modport master (
      output m_ar, m_arvalid, m_rready, s_arready, s_r, s_rvalid,
      input  m_arready, m_r, m_rvalid, s_ar, s_arvalid, s_rready
   );

endinterface

// File: rtl/axi_rd_arbiter_rr_picker.sv
// axi_rd_arbiter_rr_picker: combinational round-robin select. Returns the first set
// request found scanning ptr, ptr+1, ... modulo N. Shared with the write-path arbiter.
module axi_rd_arbiter_rr_picker #(
   parameter int unsigned N = 2,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   int unsigned k;

   // First-hit scan starting at the rotation pointer.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      k       = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (32'(ptr_i) + i) % N;
         if (!valid_o && req_i[W'(k)]) begin
            valid_o = 1'b1;
            idx_o   = W'(k);
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter for the AXI read path of NUM_M masters onto
// one slave, one burst outstanding. The grant is held from AR acceptance to RLAST.
// Optional macro AXI_RD_ARB_TIMEOUT_EN adds a hung-slave timeout (TERM/DRAIN).
module axi_rd_arbiter import axi_rd_arbiter_pkg::*; #(
   parameter int unsigned NUM_M       = 2,
   parameter int unsigned TIMEOUT_CYC = 256,
   localparam int unsigned GW = $clog2(NUM_M)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   axi_rd_arbiter_if.slave bus,
   output logic [GW-1:0]   grant_o,
   output logic            busy_o,
   output logic            proto_err_o
);

   if (NUM_M < 2 || NUM_M > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("axi_rd_arbiter: unsupported NUM_M or TIMEOUT_CYC");
   end

   arb_state_e          state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]       pick_idx, grant_nxt;
   logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
   logic                proto_err_q, proto_err_d;
   logic                pick_valid, ar_hs, r_hs;

`ifdef AXI_RD_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
   logic [TmoW-1:0]    tmo_q, tmo_d;
   logic [ID_BITS-1:0] arid_q, arid_d;
`endif

   axi_rd_arbiter_rr_picker #(
      .N (NUM_M)
   ) u_picker (
      .req_i   (bus.m_arvalid),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign grant_nxt = (grant_q == GW'(NUM_M - 1)) ? '0 : grant_q + GW'(1);
   assign ar_hs = (state_q == StAddr) && bus.m_arvalid[grant_q] && bus.s_arready;
   assign r_hs  = (state_q == StData) && bus.s_rvalid && bus.m_rready[grant_q];

   assign grant_o     = grant_q;
   assign busy_o      = (state_q != StIdle);
   assign proto_err_o = proto_err_q;

   // Next-state: arbitration in IDLE, AR hand-off, beat counting and RLAST checks.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      proto_err_d = proto_err_q;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      tmo_d  = tmo_q;
      arid_d = arid_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = StAddr;
            end
         end
         StAddr: begin
            // A master that drops ARVALID here keeps the grant; we simply wait.
            if (ar_hs) begin
               beat_cnt_d = bus.m_ar[grant_q].len;
               state_d    = StData;
`ifdef AXI_RD_ARB_TIMEOUT_EN
               tmo_d  = '0;
               arid_d = bus.m_ar[grant_q].id;
`endif
            end
         end
         StData: begin
            if (r_hs) begin
               if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - LEN_BITS'(1);
               if (bus.s_r.last) begin
                  state_d  = StIdle;
                  rr_ptr_d = grant_nxt;
                  if (beat_cnt_q != '0) proto_err_d = 1'b1;
               end else if (beat_cnt_q == '0) begin
                  proto_err_d = 1'b1;
               end
            end
`ifdef AXI_RD_ARB_TIMEOUT_EN
            if (r_hs) tmo_d = '0;
            else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) state_d = StTerm;
            else tmo_d = tmo_q + TmoW'(1);
`endif
         end
`ifdef AXI_RD_ARB_TIMEOUT_EN
         StTerm: begin
            if (bus.m_rready[grant_q]) state_d = StDrain;
         end
         StDrain: begin
            // Late slave beats are swallowed until the slave finishes its burst.
            if (bus.s_rvalid && bus.s_r.last) begin
               state_d  = StIdle;
               rr_ptr_d = grant_nxt;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Channel routing: purely a function of registered state/grant plus live inputs.
   always_comb begin
      bus.m_arready = '0;
      bus.m_r       = '0;
      bus.m_rvalid  = '0;
      bus.s_ar      = '0;
      bus.s_arvalid = 1'b0;
      bus.s_rready  = 1'b0;
      unique case (state_q)
         StAddr: begin
            bus.s_ar               = bus.m_ar[grant_q];
            bus.s_arvalid          = bus.m_arvalid[grant_q];
            bus.m_arready[grant_q] = bus.s_arready;
         end
         StData: begin
            bus.m_r[grant_q]      = bus.s_r;
            bus.m_rvalid[grant_q] = bus.s_rvalid;
            bus.s_rready          = bus.m_rready[grant_q];
         end
`ifdef AXI_RD_ARB_TIMEOUT_EN
         StTerm: begin
            bus.m_r[grant_q]      = '{id: arid_q, data: '0, resp: RESP_SLVERR, last: 1'b1};
            bus.m_rvalid[grant_q] = 1'b1;
         end
         StDrain: begin
            bus.s_rready = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         proto_err_q <= 1'b0;
`ifdef AXI_RD_ARB_TIMEOUT_EN
         tmo_q       <= '0;
         arid_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         proto_err_q <= proto_err_d;
`ifdef AXI_RD_ARB_TIMEOUT_EN
         tmo_q       <= tmo_d;
         arid_q      <= arid_d;
`endif
      end
   end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Arbitrates the AXI read path (AR + R channels) of NUM_M masters (CPU, DMA master port) onto one slave port (SDRAM or AES slave).
- Round-robin grant; exactly one read burst outstanding at a time.
- The grant is held from AR acceptance until the RLAST handshake.
- Sits inside the bus between the master-side ports and each slave's read interface.

Parameters:
NUM_M, 2, number of requesting masters (2..4)
TIMEOUT_CYC, 256, cycles allowed from AR acceptance to RLAST (used only with AXI_RD_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
m_ar_i  in  NUM_M x ar_t  per-master AR payload {id,addr,len,burst,size}
m_arvalid_i  in  NUM_M  per-master ARVALID
m_arready_o  out  NUM_M  per-master ARREADY
m_r_o  out  NUM_M x r_t  per-master R payload {id,data,resp,last}
m_rvalid_o  out  NUM_M  per-master RVALID
m_rready_i  in  NUM_M  per-master RREADY
s_ar_o  out  ar_t  slave AR payload
s_arvalid_o  out  1  slave ARVALID
s_arready_i  in  1  slave ARREADY
s_r_i  in  r_t  slave R payload
s_rvalid_i  in  1  slave RVALID
s_rready_o  out  1  slave RREADY
grant_o  out  $clog2(NUM_M)  index of the current or last granted master
busy_o  out  1  high in ADDR or DATA
proto_err_o  out  1  sticky: RLAST/beat-count mismatch seen

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state=IDLE; rr_ptr=0; grant=0; beat_cnt=0; proto_err=0.
  - All valid/ready outputs 0; all payload outputs 0.
- FSM states: IDLE, ADDR, DATA. All outputs are combinational from the registered state and grant. No combinational path from m_arvalid_i to s_arvalid_o within IDLE.
- IDLE:
  - If any m_arvalid_i is set, grant = first requester found scanning rr_ptr, rr_ptr+1, ... mod NUM_M. Register grant and go to ADDR.
  - Arbitration latency: 1 cycle.
  - All m_arready_o=0.
- ADDR:
  - s_ar_o = m_ar_i[grant]; s_arvalid_o = m_arvalid_i[grant]; m_arready_o[grant] = s_arready_i; all other masters' arready=0.
  - On the handshake: beat_cnt <= arlen, go to DATA.
  - If the granted master drops arvalid (protocol violation), stay in ADDR; the grant is not revoked.
- DATA:
  - m_r_o[grant] = s_r_i; m_rvalid_o[grant] = s_rvalid_i; s_rready_o = m_rready_i[grant].
  - Non-granted masters see rvalid=0 and payload 0.
  - IDs pass through unmodified.
  - Each R handshake decrements beat_cnt (saturates at 0).
  - Handshake with rlast=1: go to IDLE; rr_ptr <= grant+1 mod NUM_M.
  - If rlast=1 with beat_cnt!=0, or beat_cnt==0 with rlast=0 on a handshake: set proto_err_o (cleared only by reset). On the first case, still return to IDLE.
- No AR is forwarded while in DATA; a new request is accepted in IDLE the cycle after the RLAST handshake. Back-to-back burst gap is therefore 2 cycles.
- A request arriving in the same cycle as a grant decision but after the scan position waits for the next round.
- Simultaneous requests from all masters are served in strict rotation; no master waits more than NUM_M-1 bursts.
- grant_o holds its last value in IDLE. busy_o = (state!=IDLE).
- Reset mid-burst: FSM returns to IDLE immediately. The slave is responsible for its own reset; no drain is performed.

Optional Feature:
AXI_RD_ARB_TIMEOUT_EN:
- Defined:
  - A counter starts at the AR handshake and clears on each R handshake.
  - On reaching TIMEOUT_CYC in DATA, the arbiter enters TERM. In TERM it drives m_rvalid_o[grant]=1, rresp=3'b010 (SLVERR), rlast=1, data=0, id=the latched arid, until m_rready accepts.
  - It then enters DRAIN, holding s_rready_o=1 and discarding slave beats until the slave RLAST, then returns to IDLE.
- Not defined: no counter and no TERM/DRAIN states; a hung slave stalls the arbiter indefinitely.

Decomposition:
- Shared package axi_pkg:
  - ar_t and r_t structs sized from ID_BITS/ADDR_WIDTH/LEN_BITS/SIZE_BITS/DATA_WIDTH.
  - RESP_OKAY=3'b000, RESP_SLVERR=3'b010.
  - BURST_INCR.
  - FSM state enum.
- One natural sub-module: rr_picker (combinational round-robin priority select: req vector + rr_ptr -> grant index + valid). The write-path arbiter reuses it.

Test Plan:
- Single master 0, araddr=0x100, arlen=3: AR appears at the slave 1 cycle after request; 4 beats routed to m0 only; m1 rvalid stays 0; returns to IDLE; rr_ptr=1.
- m0 and m1 both request every cycle, 4 bursts of arlen=0: grants alternate 0,1,0,1; each burst has a 2-cycle gap.
- m0 rready toggled 1/0 during arlen=7: s_rready_o mirrors it; 8 beats delivered in order; no data lost or duplicated.
- Slave asserts rlast on the 2nd beat of arlen=3: proto_err_o=1 stays set; next m1 request is served normally.
- Async reset asserted mid-DATA (beat 2 of 4): all outputs 0 immediately; state=IDLE; grant_o=0.
- With AXI_RD_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave never returns R: at cycle 16 m0 receives one beat rresp=3'b010, rlast=1; late slave beats are drained, not forwarded.
